key_filter_multi: RTL and testbench
===================================

Name: key_filter_multi

Overview:
Parametrised N-channel push-button debouncer. It is the successor to the single-key filter, and adds three things per channel: press/release edge pulses, long-press detection and auto-repeat. It sits between the raw asynchronous key pins and the control FSMs. It synchronises each key, debounces it over T clock cycles, and emits one-cycle event strobes.

Parameters:
N, 4, number of independent key channels (>=1)
T, 1000000, debounce time in clk cycles (>=2); 20 ms at 50 MHz
LONG_T, 50000000, cycles of continuous debounced press before key_long fires (>=1)
REPEAT_T, 10000000, cycles between key_rpt pulses after key_long; 0 disables repeat
IDLE_LEVEL, 1, released level of the keys (1 = active-low buttons)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_in  input  N  raw asynchronous key levels
key_out  output  N  debounced key level per channel
key_press  output  N  1-cycle strobe when key_out leaves IDLE_LEVEL
key_release  output  N  1-cycle strobe when key_out returns to IDLE_LEVEL
key_long  output  N  1-cycle strobe after LONG_T cycles held
key_rpt  output  N  1-cycle strobe every REPEAT_T cycles after key_long while held

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, on port rst. All state is updated on the rising edge of clk.
- Reset: both sync flops and key_out go to IDLE_LEVEL. All strobes are 0. Debounce counter and hold counter are 0. Reset overrides all other activity, including mid-debounce and mid-hold.
- Channels are fully independent and have no shared state.
- Synchroniser: each channel has 2 flops, s0 then s1.
- Debounce counter (width $clog2(T)):
  - If s1 == key_out, the counter is cleared.
  - Otherwise, if count == T-1, then key_out <= s1 and the counter is cleared.
  - Otherwise the counter increments.
- Latency: a key_in level held stable from the first sampling edge E updates key_out at edge E+T+1, i.e. T+2 edges inclusive.
- Glitches: any excursion visible at s1 for fewer than T consecutive cycles leaves key_out unchanged and restarts the count. There is no partial credit across bounces.
- key_press / key_release are registered at the same edge key_out changes, and are high for exactly 1 cycle.
- Hold logic, per channel, with states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD at the key_press edge; the hold counter is cleared.
  - HOLD: the counter increments each cycle while key_out is active. When the counter reaches LONG_T-1, key_long is pulsed, the counter is cleared, and the state goes to REPEAT. If REPEAT_T == 0, it instead goes to a terminal wait and stays there until release.
  - REPEAT: the counter increments. At REPEAT_T-1, key_rpt is pulsed and the counter is cleared.
  - Any state -> IDLE at the key_release edge; the counter is cleared.
  - Release has priority over a coincident long or repeat threshold: no key_long or key_rpt is emitted on the release cycle.
- Strobe exclusivity: key_press, key_long and key_rpt are never high in the same cycle on one channel.
- Hold counter width is $clog2(max(LONG_T, REPEAT_T, 2)). It never wraps, because it is cleared at every threshold.
- Key held across reset release: the sync flops restart at IDLE_LEVEL. The held key is therefore debounced as a fresh press, and key_press fires T+2 cycles after rst falls.

Test Plan (N=2, T=4, LONG_T=20, REPEAT_T=8, IDLE_LEVEL=1, clk period 20 ns):
1. Reset: hold rst=1 for 10 cycles with key_in=2'b11 -> key_out=2'b11 and all strobes 0 throughout. Drop rst -> no strobe within 20 cycles.
2. Clean press on ch0: key_in[0]=0 sampled at edge E and held -> key_out[0]=0 and key_press[0]=1 at edge E+5, for exactly 1 cycle. ch1 is unaffected.
3. Bounce: toggle key_in[0] with 3-cycle low / 2-cycle high pulses for 40 cycles -> key_out[0] stays 1 and no strobes. Then hold low -> press 6 edges after the last transition.
4. Long and repeat: hold ch1 pressed -> key_long[1] 20 cycles after key_press[1], then key_rpt[1] every 8 cycles. Releasing key_in[1] -> key_release[1] at +6 edges, and key_rpt[1] stops.
5. Simultaneous events: press ch0 and ch1 on the same edge -> both key_press bits high on the same cycle. Arrange key_out release on the exact cycle the 20-cycle threshold would hit -> key_release=1 and key_long=0.
6. Reset mid-hold: assert rst while ch0 is in REPEAT with the key held -> outputs idle immediately. After rst falls -> key_press[0] 6 edges later, and key_long 20 cycles after that.

Source files
------------

// File: rtl/key_filter_multi_if.sv
// Key bundle between raw key pins, the debouncer and its consumers.
// One bit per channel on every signal.
interface key_filter_multi_if #(
  parameter int N = 4
);
  logic [N-1:0] key_in;
  logic [N-1:0] key_out;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;
  logic [N-1:0] key_rpt;

  modport master (
    output key_in,
    input  key_out,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_rpt
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_press,
    output key_release,
    output key_long,
    output key_rpt
  );
endinterface

// File: rtl/key_filter_multi.sv
// N-channel key debouncer with press/release strobes,
// long-press detection and auto-repeat.
module key_filter_multi #(
  parameter int N          = 4,
  parameter int T          = 1000000,
  parameter int LONG_T     = 50000000,
  parameter int REPEAT_T   = 10000000,
  parameter int IDLE_LEVEL = 1
) (
  input logic               clk,
  input logic               rst,
  key_filter_multi_if.slave kif
);

  localparam int CW  = (T > 1) ? $clog2(T) : 1;
  localparam int HM0 = (LONG_T > REPEAT_T) ? LONG_T : REPEAT_T;
  localparam int HM  = (HM0 > 2) ? HM0 : 2;
  localparam int HW  = $clog2(HM);

  localparam logic          IB   = (IDLE_LEVEL != 0);
  localparam logic [CW-1:0] CMAX = CW'(T - 1);
  localparam logic [HW-1:0] LMAX = HW'(LONG_T - 1);
  localparam logic [HW-1:0] RMAX =
    HW'((REPEAT_T > 0) ? REPEAT_T - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RPT,
    ST_WAIT
  } hold_e;

  logic [N-1:0]  s0_q, s1_q, out_q;
  logic [N-1:0]  prs_q, rel_q, lng_q, rpt_q;
  logic [N-1:0]  flip_d, prs_d, rel_d;
  logic [CW-1:0] cnt_q [N];
  logic [HW-1:0] hc_q  [N];
  hold_e         st_q  [N];

  always_comb begin
    flip_d = '0;
    prs_d  = '0;
    rel_d  = '0;
    for (int i = 0; i < N; i++) begin
      flip_d[i] = (s1_q[i] != out_q[i]) &&
                  (cnt_q[i] == CMAX);
      prs_d[i]  = flip_d[i] && (out_q[i] == IB);
      rel_d[i]  = flip_d[i] && (out_q[i] != IB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q  <= {N{IB}};
      s1_q  <= {N{IB}};
      out_q <= {N{IB}};
      prs_q <= '0;
      rel_q <= '0;
      lng_q <= '0;
      rpt_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        hc_q[i]  <= '0;
        st_q[i]  <= ST_IDLE;
      end
    end else begin
      s0_q  <= kif.key_in;
      s1_q  <= s0_q;
      prs_q <= prs_d;
      rel_q <= rel_d;
      lng_q <= '0;
      rpt_q <= '0;
      for (int i = 0; i < N; i++) begin
        if (s1_q[i] == out_q[i]) begin
          cnt_q[i] <= '0;
        end else if (flip_d[i]) begin
          out_q[i] <= s1_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
        // a release edge wins over any coincident threshold
        unique case (1'b1)
          rel_d[i]: begin
            st_q[i] <= ST_IDLE;
            hc_q[i] <= '0;
          end
          prs_d[i]: begin
            st_q[i] <= ST_HOLD;
            hc_q[i] <= '0;
          end
          default: begin
            unique case (st_q[i])
              ST_HOLD: begin
                if (hc_q[i] == LMAX) begin
                  lng_q[i] <= 1'b1;
                  hc_q[i]  <= '0;
                  st_q[i]  <= (REPEAT_T == 0) ? ST_WAIT
                                              : ST_RPT;
                end else begin
                  hc_q[i] <= hc_q[i] + HW'(1);
                end
              end
              ST_RPT: begin
                if (hc_q[i] == RMAX) begin
                  rpt_q[i] <= 1'b1;
                  hc_q[i]  <= '0;
                end else begin
                  hc_q[i] <= hc_q[i] + HW'(1);
                end
              end
              ST_IDLE, ST_WAIT: begin
                hc_q[i] <= '0;
              end
            endcase
          end
        endcase
      end
    end
  end

  assign kif.key_out     = out_q;
  assign kif.key_press   = prs_q;
  assign kif.key_release = rel_q;
  assign kif.key_long    = lng_q;
  assign kif.key_rpt     = rpt_q;

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: directed timing sequences, a vector
// table and random key activity against a window-based model.
module tb_key_filter_multi;
  localparam int N  = 2;
  localparam int T  = 4;
  localparam int LT = 20;
  localparam int RT = 8;
  localparam logic IB = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_filter_multi_if #(.N(N)) kif();

  key_filter_multi #(
    .N(N),
    .T(T),
    .LONG_T(LT),
    .REPEAT_T(RT),
    .IDLE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0] kin;
    int         n;
    logic [1:0] out;
    int         p0;
    int         p1;
    int         r0;
    int         r1;
  } vec_t;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [N-1:0] m_s0, m_s1, m_out;
  logic [N-1:0] m_prs, m_rel, m_lng, m_rpt;
  logic [T-1:0] m_win [N];
  int           m_seen [N];
  bit           m_held [N];
  int           m_pst  [N];

  int np[N], nrl[N], nl[N], nr[N];
  int lp[N], lrl[N], ll[N], lr[N];

  task automatic chk(input string nm, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      np[c] = 0; nrl[c] = 0; nl[c] = 0; nr[c] = 0;
      lp[c] = -1; lrl[c] = -1; ll[c] = -1; lr[c] = -1;
    end
  endtask

  function automatic int nstr();
    int s = 0;
    for (int c = 0; c < N; c++)
      s += np[c] + nrl[c] + nl[c] + nr[c];
    return s;
  endfunction

  // key_out flips once the last T synchronised samples all
  // disagree with it; hold events are timed from the press edge
  task automatic model_edge(input logic r,
                            input logic [N-1:0] kin);
    logic pre, flip;
    int d;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        m_s0[c] = IB; m_s1[c] = IB; m_out[c] = IB;
        m_prs[c] = 0; m_rel[c] = 0;
        m_lng[c] = 0; m_rpt[c] = 0;
        m_win[c] = '0; m_seen[c] = 0;
        m_held[c] = 0; m_pst[c] = 0;
      end else begin
        pre = m_s1[c];
        m_s1[c] = m_s0[c];
        m_s0[c] = kin[c];
        m_win[c] = {m_win[c][T-2:0], pre};
        if (m_seen[c] < T) m_seen[c]++;
        flip = (m_seen[c] >= T) &&
               (m_win[c] == {T{~m_out[c]}});
        m_prs[c] = flip && (m_out[c] == IB);
        m_rel[c] = flip && (m_out[c] != IB);
        if (flip) m_out[c] = ~m_out[c];
        if (m_prs[c]) begin
          m_held[c] = 1;
          m_pst[c] = cyc;
        end
        if (m_rel[c]) m_held[c] = 0;
        d = cyc - m_pst[c];
        m_lng[c] = m_held[c] && !m_prs[c] && d == LT;
        m_rpt[c] = m_held[c] && !m_prs[c] && RT > 0 &&
                   d > LT && ((d - LT) % RT) == 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_edge(rst, kif.key_in);
      #1;
      chk("key_out", kif.key_out, m_out);
      chk("key_press", kif.key_press, m_prs);
      chk("key_release", kif.key_release, m_rel);
      chk("key_long", kif.key_long, m_lng);
      chk("key_rpt", kif.key_rpt, m_rpt);
      for (int c = 0; c < N; c++) begin
        if (kif.key_press[c]) begin np[c]++; lp[c] = cyc; end
        if (kif.key_release[c]) begin
          nrl[c]++; lrl[c] = cyc;
        end
        if (kif.key_long[c]) begin nl[c]++; ll[c] = cyc; end
        if (kif.key_rpt[c]) begin nr[c]++; lr[c] = cyc; end
      end
    end
  end

  initial begin
    vec_t tbl[10];
    int p, f;
    int tmr[N];
    tbl[0] = '{2'b11, 8, 2'b11, 0, 0, 0, 0};
    tbl[1] = '{2'b10, 3, 2'b11, 0, 0, 0, 0};
    tbl[2] = '{2'b11, 8, 2'b11, 0, 0, 0, 0};
    tbl[3] = '{2'b10, 8, 2'b10, 1, 0, 0, 0};
    tbl[4] = '{2'b11, 3, 2'b10, 0, 0, 0, 0};
    tbl[5] = '{2'b10, 8, 2'b10, 0, 0, 0, 0};
    tbl[6] = '{2'b11, 8, 2'b11, 0, 0, 1, 0};
    tbl[7] = '{2'b01, 8, 2'b01, 0, 1, 0, 0};
    tbl[8] = '{2'b10, 8, 2'b10, 1, 0, 0, 1};
    tbl[9] = '{2'b11, 8, 2'b11, 0, 0, 1, 0};
    for (int c = 0; c < N; c++) tmr[c] = 0;

    kif.key_in = 2'b11;
    rst = 1'b1;
    clr();
    repeat (10) @(negedge clk);
    chk("rst_out", kif.key_out, 2'b11);
    chk("rst_strobes", nstr(), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_quiet", nstr(), 0);

    clr();
    kif.key_in[0] = 1'b0;
    p = cyc + 6;
    repeat (10) @(negedge clk);
    chk("press_time", lp[0], p);
    chk("press_len", np[0], 1);
    chk("press_out", kif.key_out, 2'b10);
    chk("ch1_quiet", np[1] + nrl[1] + nl[1] + nr[1], 0);
    kif.key_in = 2'b11;
    repeat (30) @(negedge clk);

    clr();
    for (int k = 0; k < 8; k++) begin
      kif.key_in[0] = 1'b0;
      repeat (3) @(negedge clk);
      kif.key_in[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    chk("bounce_out", kif.key_out[0], 1);
    chk("bounce_quiet", nstr(), 0);
    kif.key_in[0] = 1'b0;
    p = cyc + 6;
    repeat (8) @(negedge clk);
    chk("bounce_press", lp[0], p);
    kif.key_in = 2'b11;
    repeat (12) @(negedge clk);

    clr();
    kif.key_in[1] = 1'b0;
    p = cyc + 6;
    while (cyc < p + 40) @(negedge clk);
    kif.key_in[1] = 1'b1;
    while (cyc < p + 60) @(negedge clk);
    chk("hold_press", lp[1], p);
    chk("hold_long_t", ll[1], p + 20);
    chk("hold_long_n", nl[1], 1);
    chk("hold_rpt_n", nr[1], 3);
    chk("hold_rpt_last", lr[1], p + 44);
    chk("hold_rel_t", lrl[1], p + 46);

    clr();
    kif.key_in = 2'b00;
    p = cyc + 6;
    while (cyc < p + 14) @(negedge clk);
    kif.key_in = 2'b11;
    while (cyc < p + 30) @(negedge clk);
    chk("sim_press0", lp[0], p);
    chk("sim_press1", lp[1], p);
    chk("sim_rel0", lrl[0], p + 20);
    chk("sim_rel1", lrl[1], p + 20);
    chk("sim_no_long", nl[0] + nl[1], 0);

    clr();
    kif.key_in[0] = 1'b0;
    p = cyc + 6;
    while (cyc < p + 30) @(negedge clk);
    chk("mid_rpt", nr[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", kif.key_out, 2'b11);
    chk("mid_rst_str", kif.key_press | kif.key_release |
        kif.key_long | kif.key_rpt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
    f = cyc + 1;
    while (cyc < f + 30) @(negedge clk);
    chk("rearm_press", lp[0], f + 5);
    chk("rearm_long", ll[0], f + 25);
    chk("rearm_press_n", np[0], 1);
    kif.key_in = 2'b11;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      clr();
      kif.key_in = tbl[i].kin;
      repeat (tbl[i].n) @(negedge clk);
      chk($sformatf("tbl%0d_out", i), kif.key_out, tbl[i].out);
      chk($sformatf("tbl%0d_p0", i), np[0], tbl[i].p0);
      chk($sformatf("tbl%0d_p1", i), np[1], tbl[i].p1);
      chk($sformatf("tbl%0d_r0", i), nrl[0], tbl[i].r0);
      chk($sformatf("tbl%0d_r1", i), nrl[1], tbl[i].r1);
    end

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        if (tmr[c] == 0) begin
          kif.key_in[c] = 1'($urandom_range(0, 1));
          tmr[c] = ($urandom_range(0, 7) == 0) ?
                   $urandom_range(25, 60) :
                   $urandom_range(1, 7);
        end else begin
          tmr[c]--;
        end
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
